// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: mode encodings, the driver
// FSM state type and the reference result function used by the optional
// result checker (enabled by defining RESULT_CHECK_EN).
package alu_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_GT  = 2'b10;
    localparam logic [1:0] MODE_SHR = 2'b11;

    // Width of one queued command: {mode, b, a}
    localparam int CMD_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Result the ALU is expected to produce for a given operand/mode triple
    function automatic logic [7:0] alu_golden(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [1:0] mode);
        logic [7:0] r;
        r = 8'd0;
        case (mode)
            MODE_ADD: r = {4'b0, a} + {4'b0, b};
            MODE_AND: r = {4'b0, a & b};
            MODE_GT:  r = (a > b) ? 8'd1 : 8'd0;
            default:  r = {4'b0, a >> b};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU driver. DEPTH entries (power of two) of W bits,
// head presented combinationally on rdata. A push together with a pop is
// accepted even when full, because the pop frees the slot at the same edge.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally mod DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_driver.sv
// Command-side driver for the 4-bit ALU. Buffers requests in a FIFO, holds
// operands on alu_a/alu_b/alu_mode for one full cycle, captures alu_out and
// returns results in order on the response channel.
// Optional feature: define RESULT_CHECK_EN to compare alu_out against an
// internal reference at capture time and raise a sticky err on mismatch.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its payload stable until that edge;
// cmd_ready depends only on registered state (and rst), never on cmd_valid.
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_mode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_mode,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_mode,
    output logic       busy,
    output logic       err
);

    state_t           state;
    state_t           state_nx;
    logic             pop;
    logic             capture;
    logic             rsp_release;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;

    assign push      = cmd_valid && cmd_ready;
    assign cmd_ready = !rst && !fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_mode, cmd_b, cmd_a}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus pop/capture strobes; in HOLD rsp_valid is always high,
    // so rsp_ready alone completes the response handshake
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        capture     = 1'b0;
        rsp_release = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                capture  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_release = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = ISSUE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ALU operand registers change only when a command is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_mode <= 2'd0;
        end else if (pop) begin
            alu_a    <= fifo_rdata[3:0];
            alu_b    <= fifo_rdata[7:4];
            alu_mode <= fifo_rdata[9:8];
        end
    end

    // Response capture and release
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_mode  <= 2'd0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_mode  <= alu_mode;
        end else if (rsp_release) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef RESULT_CHECK_EN
    logic [7:0] golden;
    assign golden = alu_golden(alu_a, alu_b, alu_mode);

    // Sticky flag: any captured result that disagrees with the reference
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (capture && (alu_out != golden)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: directed command vectors, a stand-in combinational
// ALU, and a response scoreboard fed from the command handshakes.
module tb_alu_op_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_mode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_mode;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_mode;
  logic       busy;
  logic       err;

  logic       inject = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         n_rsp = 0;
  logic [9:0] exp_q[$];

  logic       hold_prev = 1'b0;
  logic [7:0] prev_data;
  logic [1:0] prev_mode;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  alu_op_driver #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_mode  (cmd_mode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_mode  (rsp_mode),
    .busy      (busy),
    .err       (err)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] m);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (m)
      2'd0:    r = ia + ib;
      2'd1:    r = int'(a & b);
      2'd2:    r = (ia > ib) ? 1 : 0;
      default: r = ia / (1 << ib);
    endcase
    return 8'(r);
  endfunction

  function automatic logic is_bad(input logic [3:0] a, input logic [3:0] b,
                                  input logic [1:0] m);
    return inject && (a == 4'd1) && (b == 4'd1) && (m == 2'd0);
  endfunction

  // Stand-in ALU; returns a wrong value for 1+1 ADD while inject is set
  assign alu_out = is_bad(alu_a, alu_b, alu_mode) ? 8'hFF : ref_alu(alu_a, alu_b, alu_mode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
        check("rsp_hold_mode", 32'(rsp_mode), 32'(prev_mode));
      end
      if (exp_q.size() >= DEPTH + 1) begin
        check("cmd_ready_at_capacity", 32'(cmd_ready), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got response %0h, required none pending (t=%0t)",
                   rsp_data, $time);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          check("rsp_mode", 32'(rsp_mode), 32'(e[9:8]));
          n_rsp++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back({cmd_mode,
                         is_bad(cmd_a, cmd_b, cmd_mode) ? 8'hFF : ref_alu(cmd_a, cmd_b, cmd_mode)});
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_mode = rsp_mode;
`ifndef RESULT_CHECK_EN
      check("err_tied_low", 32'(err), 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one command; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    cmd_a = a;
    cmd_b = b;
    cmd_mode = m;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: cmd_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_drain: outstanding=%0d busy=%0b, required 0 and 0", name, exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] t2_a [5] = '{4'd3, 4'd4, 4'hC, 4'b1000, 4'b1000};
  logic [3:0] t2_b [5] = '{4'd3, 4'd3, 4'hA, 4'd3, 4'd4};
  logic [1:0] t2_m [5] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11};

  initial begin
    int acc;
    int rsp0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 4'd0;
    cmd_b = 4'd0;
    cmd_mode = 2'd0;
    rsp_ready = 1'b0;

    // Model pinned against hand-computed values
    check("model_add_9_7", 32'(ref_alu(4'd9, 4'd7, 2'b00)), 32'd16);
    check("model_gt_3_3", 32'(ref_alu(4'd3, 4'd3, 2'b10)), 32'd0);
    check("model_gt_4_3", 32'(ref_alu(4'd4, 4'd3, 2'b10)), 32'd1);
    check("model_and_c_a", 32'(ref_alu(4'hC, 4'hA, 2'b01)), 32'h08);
    check("model_shr_8_3", 32'(ref_alu(4'b1000, 4'd3, 2'b11)), 32'd1);
    check("model_shr_8_4", 32'(ref_alu(4'b1000, 4'd4, 2'b11)), 32'd0);
    check("model_add_f_f", 32'(ref_alu(4'hF, 4'hF, 2'b00)), 32'd30);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_regs", 32'({alu_a, alu_b, alu_mode}), 32'd0);
    check("rst_rsp_data", 32'({rsp_data, rsp_mode}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 1: single ADD, latency of two edges from accept to rsp_valid
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(4'd9, 4'd7, 2'b00);
    @(negedge clk);
    check("t1_valid_t0", 32'(rsp_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_valid_t1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_t2", 32'(rsp_valid), 32'd1);
    check("t1_data", 32'(rsp_data), 32'd16);
    check("t1_mode", 32'(rsp_mode), 32'd0);
    drain("t1");

    // 2: compare, AND and shift vectors
    for (int i = 0; i < 5; i++) begin
      send(t2_a[i], t2_b[i], t2_m[i]);
    end
    drain("t2");

    // 3: backpressure capacity, then release
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_a = 4'(acc * 3 + 1);
      cmd_b = 4'(acc + 2);
      cmd_mode = 2'(acc);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'(DEPTH + 1));
    @(negedge clk);
    check("t3_ready_low", 32'(cmd_ready), 32'd0);
    check("t3_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_before_pop", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
    drain("t3");

    // 4: refill to capacity, then push and pop concurrently
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(4'(i + 5), 4'(i), 2'b00);
    end
    rsp0 = n_rsp;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      cmd_a = 4'(acc + 2);
      cmd_b = 4'(15 - acc);
      cmd_mode = 2'(acc + 1);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    drain("t4");
    check("t4_no_loss", 32'(n_rsp - rsp0), 32'(DEPTH + 1 + acc));

    // 5: reset while holding a response with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 1), 4'd2, 2'b01);
    end
    repeat (2) @(negedge clk);
    check("t5_holding", 32'(rsp_valid), 32'd1);
    do_reset(1);
    @(negedge clk);
    check("t5_valid_after_rst", 32'(rsp_valid), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // 6: bad ALU result for 1+1, then good ops, then reset
    inject = 1'b1;
    send(4'd1, 4'd1, 2'b00);
    drain("t6_bad");
    inject = 1'b0;
`ifdef RESULT_CHECK_EN
    check("t6_err_set", 32'(err), 32'd1);
`else
    check("t6_err_off", 32'(err), 32'd0);
`endif
    send(4'd2, 4'd3, 2'b00);
    send(4'd5, 4'd1, 2'b11);
    drain("t6_good");
`ifdef RESULT_CHECK_EN
    check("t6_err_sticky", 32'(err), 32'd1);
`else
    check("t6_err_still_off", 32'(err), 32'd0);
`endif
    do_reset(2);
    @(negedge clk);
    check("t6_err_cleared", 32'(err), 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
